ram_fifo_ctrl: RTL
==================

# ram_fifo_ctrl

Synchronous FIFO controller that turns the single-clock dual-port RAM into a streaming first-in-first-out buffer. It sits directly upstream of the RAM: it generates the RAM write-port and read-port signals from a valid/ready push stream, and consumes the RAM's registered read data. A 2-entry output buffer hides the RAM's 1-cycle read latency and presents a valid/ready pop stream at full throughput.

## Interface
- ADDR_WIDTH, 8, RAM address width.
- DATA_WIDTH, 8, data width.
- DEPTH, 2**ADDR_WIDTH (256), RAM entries; must be a power of two.
- AF_THRESH, DEPTH-4, almost_full threshold on level (only with RAM_FIFO_STATUS_EN).
- AE_THRESH, 4, almost_empty threshold on level (only with RAM_FIFO_STATUS_EN).

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high. It is wired to the RAM's rst as well.
- in_valid  in  1  push request.
- in_ready  out  1  push accepted when in_valid && in_ready.
- in_data  in  DATA_WIDTH  push data.
- out_valid  out  1  out_data holds the FIFO head.
- out_ready  in  1  pop when out_valid && out_ready.
- out_data  out  DATA_WIDTH  head data, registered.
- level  out  ADDR_WIDTH+2  total entries held (RAM + in-flight read + buffer), 0..DEPTH+2.
- ram_wr_enbl  out  1  RAM write enable.
- ram_wr_addr  out  ADDR_WIDTH  RAM write address (write pointer).
- ram_wr_data  out  DATA_WIDTH  equals in_data.
- ram_rd_enbl  out  1  RAM read enable.
- ram_rd_addr  out  ADDR_WIDTH  RAM read address (read pointer).
- ram_rd_data  in  DATA_WIDTH  RAM read data, valid the cycle after ram_rd_enbl.
- almost_full, almost_empty  out  1 each  only with RAM_FIFO_STATUS_EN.

## Operation
- State: wr_ptr and rd_ptr (ADDR_WIDTH, wrap modulo DEPTH); mem_count (0..DEPTH); rd_pending (1 bit); a 2-entry output buffer with buf_count (0..2).
- Push: in_ready = !rst && (mem_count != DEPTH). On acceptance, ram_wr_enbl=1 at wr_ptr, and wr_ptr increments. in_ready does not look ahead to same-cycle RAM reads.
- Read issue: pop = out_valid && out_ready. ram_rd_enbl = (mem_count != 0) && (buf_count + rd_pending - pop < 2). On issue, rd_ptr increments.
- mem_count: +1 on push, -1 on read issue, unchanged when both occur.
- Capture: when rd_pending=1, ram_rd_data is written into the buffer tail in that cycle. rd_pending is the registered ram_rd_enbl.
- out_valid = (buf_count != 0). out_data = buffer head. Pop and capture may occur in the same cycle.
- level = mem_count + rd_pending + buf_count.
- Read-after-write hazard: none. A read is issued only on entries whose write committed at an earlier edge.
- Reset: wr_ptr, rd_ptr, mem_count, rd_pending and buf_count are cleared to 0. During reset, out_valid=0, out_data=0, level=0, in_ready=0, and all ram_* enables=0. Reset asserted mid-operation discards all contents, including any in-flight read.

## Timing
- Push to out_valid latency on an empty FIFO is 3 cycles:
  - write at edge E0;
  - ram_rd_enbl asserted in cycle 1;
  - ram_rd_data present in cycle 2, captured at E2;
  - out_valid=1 in cycle 3.
- Throughput is 1 push and 1 pop per cycle sustained, with no bubbles once the buffer is primed.
- Maximum capacity is DEPTH+2 entries. in_ready deasserts when mem_count==DEPTH.
- out_data is stable while out_valid && !out_ready.

## Configuration
- RAM_FIFO_STATUS_EN defined:
  - almost_full is registered and equals (level_next >= AF_THRESH).
  - almost_empty is registered and equals (level_next <= AE_THRESH).
  - Reset values: almost_full=0, almost_empty=1.
- RAM_FIFO_STATUS_EN not defined: the almost_full and almost_empty ports and their logic are absent.

## Test plan
- After reset: push 0x11, 0x22, 0x33 in consecutive cycles with out_ready=1. Required: out_valid first rises 3 cycles after the 0x11 push; 0x11, 0x22, 0x33 are then popped in consecutive cycles.
- out_ready=0, push 258 values 0..257 (mod 256). Required: level=258; in_ready deasserts after the 258th accept; ram_wr_addr wraps 0xFF->0x00.
- Full FIFO, then out_ready=1 and in_valid=1 continuously for 1000 cycles. Required: exactly one pop per cycle after pipeline refill, data strictly in order, no loss and no duplication.
- Random out_ready backpressure with 2 entries in the buffer. Required: out_data is held while stalled; ram_rd_enbl never makes buf_count+rd_pending exceed 2.
- Assert rst for 1 cycle with level=100 and a read in flight. Required: the next cycle shows out_valid=0 and level=0; the next push of 0xA5 pops as 0xA5.
- With RAM_FIFO_STATUS_EN, AF_THRESH=252, AE_THRESH=4. Required: almost_empty drops on the 5th entry; almost_full rises when level reaches 252.

Source files
------------

// File: rtl/ram_fifo_ctrl_if.sv
// Stream and RAM-port bundle for ram_fifo_ctrl.
// The slave modport is the controller side; master is the producer/consumer/RAM environment.
interface ram_fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  ram_wr_enbl;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic                  ram_rd_enbl;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  modport master (
    output in_valid, in_data, out_ready, ram_rd_data,
    input  in_ready, out_valid, out_data,
    input  ram_wr_enbl, ram_wr_addr, ram_wr_data, ram_rd_enbl, ram_rd_addr
  );

  modport slave (
    input  in_valid, in_data, out_ready, ram_rd_data,
    output in_ready, out_valid, out_data,
    output ram_wr_enbl, ram_wr_addr, ram_wr_data, ram_rd_enbl, ram_rd_addr
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around a 1-cycle-latency dual-port RAM with a 2-entry output buffer.
// Optional almost_full/almost_empty status outputs are built when RAM_FIFO_STATUS_EN is defined.
module ram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2**ADDR_WIDTH
`ifdef RAM_FIFO_STATUS_EN
  ,
  parameter int AF_THRESH  = DEPTH-4,
  parameter int AE_THRESH  = 4
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_fifo_ctrl_if.slave        bus_if,
  output logic [ADDR_WIDTH+1:0] level_o
`ifdef RAM_FIFO_STATUS_EN
  ,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
`endif
);
  localparam int LW = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH:0] MEM_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   mem_count_q, mem_count_d;
  logic                  rd_pending_q, rd_pending_d;
  logic [1:0]            buf_count_q, buf_count_d;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [DATA_WIDTH-1:0] buf_d [2];

  logic       in_ready;
  logic       out_valid;
  logic       push;
  logic       pop;
  logic       rd_issue;
  logic [2:0] occ_next;

  // Buffer occupancy after this cycle's pop and capture; a new read may only be
  // issued if the returning word will still find a free slot.
  always_comb begin
    in_ready  = !rst && (mem_count_q != MEM_FULL);
    push      = bus_if.in_valid && in_ready;
    out_valid = !rst && (buf_count_q != 2'd0);
    pop       = out_valid && bus_if.out_ready;
    occ_next  = {1'b0, buf_count_q} + {2'b00, rd_pending_q} - {2'b00, pop};
    rd_issue  = !rst && (mem_count_q != '0) && (occ_next < 3'd2);
  end

  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d     = rd_issue ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    rd_pending_d = rd_issue;
    buf_count_d  = occ_next[1:0];
    mem_count_d  = mem_count_q;
    unique case ({push, rd_issue})
      2'b10:   mem_count_d = mem_count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   mem_count_d = mem_count_q - (ADDR_WIDTH+1)'(1);
      default: mem_count_d = mem_count_q;
    endcase
  end

  // Head shifts on pop; the returning word lands in the first slot left free.
  always_comb begin
    buf_d = buf_q;
    if (pop) begin
      buf_d[0] = buf_q[1];
    end
    if (rd_pending_q) begin
      if (buf_count_q == {1'b0, pop}) begin
        buf_d[0] = bus_if.ram_rd_data;
      end else begin
        buf_d[1] = bus_if.ram_rd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_count_q  <= '0;
      rd_pending_q <= 1'b0;
      buf_count_q  <= 2'd0;
      buf_q[0]     <= '0;
      buf_q[1]     <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_count_q  <= mem_count_d;
      rd_pending_q <= rd_pending_d;
      buf_count_q  <= buf_count_d;
      buf_q        <= buf_d;
    end
  end

  assign bus_if.in_ready    = in_ready;
  assign bus_if.out_valid   = out_valid;
  assign bus_if.out_data    = rst ? '0 : buf_q[0];
  assign bus_if.ram_wr_enbl = push;
  assign bus_if.ram_wr_addr = wr_ptr_q;
  assign bus_if.ram_wr_data = bus_if.in_data;
  assign bus_if.ram_rd_enbl = rd_issue;
  assign bus_if.ram_rd_addr = rd_ptr_q;

  assign level_o = rst ? '0 : LW'(mem_count_q) + LW'(rd_pending_q) + LW'(buf_count_q);

`ifdef RAM_FIFO_STATUS_EN
  logic [LW-1:0] level_next;
  logic          almost_full_q;
  logic          almost_empty_q;

  assign level_next = LW'(mem_count_d) + LW'(rd_pending_d) + LW'(buf_count_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (int'(level_next) >= AF_THRESH);
      almost_empty_q <= (int'(level_next) <= AE_THRESH);
    end
  end

  assign almost_full_o  = almost_full_q;
  assign almost_empty_o = almost_empty_q;
`endif
endmodule
